// File: rtl/regfile_32_if.sv
// regfile_32_if: register-file access bundle between the pipeline and regfile_32.
//   master : pipeline side. Drives the WB-stage write (RegWrite, WriteRegister,
//            WriteData) and the ID-stage read indices (ReadRegister1/2), and
//            receives ReadData1/2.
//   slave  : register file side. The directions are the reverse of master.
// WIDTH is the data width and must match the WIDTH of the attached regfile_32.
interface regfile_32_if #(
   parameter int unsigned WIDTH = 64
);
   logic             RegWrite;
   logic [4:0]       WriteRegister;
   logic [WIDTH-1:0] WriteData;
   logic [4:0]       ReadRegister1;
   logic [4:0]       ReadRegister2;
   logic [WIDTH-1:0] ReadData1;
   logic [WIDTH-1:0] ReadData2;

   modport master (
      output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      input  ReadData1, ReadData2
   );

   modport slave (
      input  RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2
   );
endinterface

// File: rtl/regfile_32.sv
// regfile_32: architectural register file with 32 x WIDTH registers.
//   clk    : system clock. All state changes on its rising edge.
//   reset  : synchronous, active-low. Clears every register and overrides a
//            write presented on the same edge.
//   rf     : regfile_32_if.slave. Carries one write port (RegWrite,
//            WriteRegister, WriteData) and two combinational read ports
//            (ReadRegisterN -> ReadDataN).
// Register ZERO_REG always reads as zero, and writes to it are discarded.
// Optional macro REGFILE_BYPASS_EN: when it is defined, a read of the register
// being written in the current cycle returns WriteData. When it is undefined,
// the read returns the value stored before the edge.
//
// decoder_32: 5-to-32 one-hot decoder with enable.
//   in  : index to decode.
//   en  : enable. When it is low the output is all zeros, whatever `in` holds.
//   out : one-hot select, or zero.
module decoder_32 (
   input  logic [4:0]  in,
   input  logic        en,
   output logic [31:0] out
);
   always_comb begin
      out = '0;
      if (en) begin
         out = 32'd1 << in;
      end
   end
endmodule

module regfile_32 #(
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned ZERO_REG = 31
) (
   input  logic          clk,
   input  logic          reset,
   regfile_32_if.slave   rf
);
   localparam logic [4:0] ZERO_IDX = ZERO_REG[4:0];

   logic [31:0]      wr_sel;
   logic [WIDTH-1:0] regs_q [32];
   logic [WIDTH-1:0] regs_d [32];
   logic [WIDTH-1:0] rd1;
   logic [WIDTH-1:0] rd2;

   decoder_32 u_wr_dec (
      .in  (rf.WriteRegister),
      .en  (rf.RegWrite),
      .out (wr_sel)
   );

   always_comb begin
      for (int unsigned i = 0; i < 32; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_sel[i] && (i != ZERO_REG)) begin
            regs_d[i] = rf.WriteData;
         end
      end
      regs_d[ZERO_REG] = '0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 32; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Read order: stored value, then the zero-register override, then the
   // optional bypass. The bypass excludes ZERO_IDX, so the zero register
   // always reads as zero.
   always_comb begin
      rd1 = regs_q[rf.ReadRegister1];
      rd2 = regs_q[rf.ReadRegister2];
      if (rf.ReadRegister1 == ZERO_IDX) rd1 = '0;
      if (rf.ReadRegister2 == ZERO_IDX) rd2 = '0;
`ifdef REGFILE_BYPASS_EN
      if (rf.RegWrite && (rf.WriteRegister != ZERO_IDX)) begin
         if (rf.WriteRegister == rf.ReadRegister1) rd1 = rf.WriteData;
         if (rf.WriteRegister == rf.ReadRegister2) rd2 = rf.WriteData;
      end
`endif
   end

   assign rf.ReadData1 = rd1;
   assign rf.ReadData2 = rd2;

   a_wr_sel_onehot0: assert property (@(posedge clk) $onehot0(wr_sel));
endmodule

// File: tb/tb_regfile_32.sv
module tb_regfile_32;
   localparam int unsigned W = 64;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   logic [W-1:0] model [32];

   regfile_32_if #(.WIDTH(W)) rf_bus ();

   regfile_32 #(.WIDTH(W), .ZERO_REG(31)) dut (
      .clk   (clk),
      .reset (reset),
      .rf    (rf_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference read for the current inputs. The zero register always reads 0.
   // In the bypass build, a read of the register being written returns WriteData.
   function automatic logic [W-1:0] exp_rd(input logic [4:0] idx);
      if (idx == 5'd31) return '0;
`ifdef REGFILE_BYPASS_EN
      if (rf_bus.RegWrite && rf_bus.WriteRegister == idx) return rf_bus.WriteData;
`endif
      return model[idx];
   endfunction

   // Update the model from the inputs presented before the edge, then advance one cycle.
   task automatic cycle();
      if (!reset) begin
         for (int i = 0; i < 32; i++) model[i] = '0;
      end else if (rf_bus.RegWrite && rf_bus.WriteRegister != 5'd31) begin
         model[rf_bus.WriteRegister] = rf_bus.WriteData;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] idx, input logic [W-1:0] data);
      rf_bus.RegWrite      = 1'b1;
      rf_bus.WriteRegister = idx;
      rf_bus.WriteData     = data;
      cycle();
      rf_bus.RegWrite      = 1'b0;
   endtask

   task automatic rd_set(input logic [4:0] a, input logic [4:0] b);
      rf_bus.ReadRegister1 = a;
      rf_bus.ReadRegister2 = b;
      #1;
   endtask

   task automatic rd_model(input string tag, input logic [4:0] a, input logic [4:0] b);
      rd_set(a, b);
      check({tag, "_p1"}, rf_bus.ReadData1, exp_rd(a));
      check({tag, "_p2"}, rf_bus.ReadData2, exp_rd(b));
   endtask

   initial begin
      logic [W-1:0] coll_exp;
      n_cmp = 0;
      n_err = 0;
      for (int i = 0; i < 32; i++) model[i] = '0;
      reset                = 1'b0;
      rf_bus.RegWrite      = 1'b0;
      rf_bus.WriteRegister = '0;
      rf_bus.WriteData     = '0;
      rf_bus.ReadRegister1 = '0;
      rf_bus.ReadRegister2 = '0;
      cycle();
      cycle();
      reset = 1'b1;

      // Reset state
      rd_set(5'd0, 5'd17);
      check("rst_r0", rf_bus.ReadData1, '0);
      check("rst_r17", rf_bus.ReadData2, '0);

      // Reset clear, with a write presented on the reset edge
      wr(5'd5, 64'hDEAD);
      rd_set(5'd5, 5'd5);
      check("preload_r5", rf_bus.ReadData1, 64'hDEAD);
      reset = 1'b0;
      rf_bus.RegWrite      = 1'b1;
      rf_bus.WriteRegister = 5'd7;
      rf_bus.WriteData     = 64'h1234;
      cycle();
      reset = 1'b1;
      rf_bus.RegWrite = 1'b0;
      rd_set(5'd5, 5'd0);
      check("rstclr_r5", rf_bus.ReadData1, '0);
      check("rstclr_r0", rf_bus.ReadData2, '0);
      rd_set(5'd7, 5'd7);
      check("rstwr_r7", rf_bus.ReadData1, '0);

      // Basic write and read
      wr(5'd0, 64'h1);
      wr(5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
      wr(5'd30, 64'h0123_4567_89AB_CDEF);
      rd_set(5'd1, 5'd30);
      check("basic_r1", rf_bus.ReadData1, 64'hFFFF_FFFF_FFFF_FFFF);
      check("basic_r30", rf_bus.ReadData2, 64'h0123_4567_89AB_CDEF);
      rd_set(5'd0, 5'd0);
      check("basic_r0", rf_bus.ReadData2, 64'h1);

      // Zero register: both ports read 0 during the write and after it
      rf_bus.RegWrite      = 1'b1;
      rf_bus.WriteRegister = 5'd31;
      rf_bus.WriteData     = 64'hABCD;
      rd_set(5'd31, 5'd31);
      check("zr_during_p1", rf_bus.ReadData1, '0);
      check("zr_during_p2", rf_bus.ReadData2, '0);
      cycle();
      rf_bus.RegWrite = 1'b0;
      rd_set(5'd31, 5'd31);
      check("zr_after_p1", rf_bus.ReadData1, '0);
      check("zr_after_p2", rf_bus.ReadData2, '0);
      for (int i = 0; i < 31; i += 2) rd_model("zr_others", 5'(i), 5'(i + 1));

      // Write disabled, and an X index with the enable low
      rf_bus.RegWrite      = 1'b0;
      rf_bus.WriteRegister = 5'd4;
      rf_bus.WriteData     = 64'h55;
      cycle();
      rf_bus.WriteRegister = 5'bx;
      cycle();
      rd_set(5'd4, 5'd4);
      check("wrdis_r4", rf_bus.ReadData1, '0);
      check("wrdis_r1", model[1], 64'hFFFF_FFFF_FFFF_FFFF);
      rd_set(5'd1, 5'd1);
      check("wrdis_r1_rd", rf_bus.ReadData2, 64'hFFFF_FFFF_FFFF_FFFF);

      // Same-cycle collision on R9
      wr(5'd9, 64'h10);
      rf_bus.RegWrite      = 1'b1;
      rf_bus.WriteRegister = 5'd9;
      rf_bus.WriteData     = 64'h20;
      rd_set(5'd9, 5'd9);
`ifdef REGFILE_BYPASS_EN
      coll_exp = 64'h20;
`else
      coll_exp = 64'h10;
`endif
      check("coll_pre_p1", rf_bus.ReadData1, coll_exp);
      check("coll_pre_p2", rf_bus.ReadData2, coll_exp);
      cycle();
      rf_bus.RegWrite = 1'b0;
      rd_set(5'd9, 5'd9);
      check("coll_post_p1", rf_bus.ReadData1, 64'h20);
      check("coll_post_p2", rf_bus.ReadData2, 64'h20);

      // Back-to-back writes to one register: the last write wins
      wr(5'd12, 64'hAAAA);
      wr(5'd12, 64'hBBBB);
      rd_set(5'd12, 5'd12);
      check("b2b_r12", rf_bus.ReadData1, 64'hBBBB);

      // Sweep: R[i] = i*0x0101 for i = 0..30
      for (int i = 0; i < 31; i++) wr(5'(i), 64'(i * 32'h0101));
      for (int i = 0; i < 32; i++) begin
         rd_set(5'(i), 5'(31 - i));
         check("sweep_p1", rf_bus.ReadData1, (i == 31) ? 64'h0 : 64'(i * 32'h0101));
         check("sweep_p2", rf_bus.ReadData2, (i == 0) ? 64'h0 : 64'((31 - i) * 32'h0101));
      end

      // Randomized traffic checked against the array model
      for (int n = 0; n < 400; n++) begin
         reset                = ($urandom_range(0, 49) != 0);
         rf_bus.RegWrite      = $urandom_range(0, 1) == 1;
         rf_bus.WriteRegister = 5'($urandom_range(0, 31));
         rf_bus.WriteData     = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) begin
            rd_set(rf_bus.WriteRegister, 5'($urandom_range(0, 31)));
         end else begin
            rd_set(5'($urandom_range(0, 31)), rf_bus.WriteRegister);
         end
         if (reset) begin
            check("rand_p1", rf_bus.ReadData1, exp_rd(rf_bus.ReadRegister1));
            check("rand_p2", rf_bus.ReadData2, exp_rd(rf_bus.ReadRegister2));
         end
         cycle();
      end
      reset = 1'b1;
      rf_bus.RegWrite = 1'b0;
      for (int i = 0; i < 32; i++) rd_model("final", 5'(i), 5'(31 - i));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/regfile_32.md
# regfile_32

Architectural register file for the 5-stage pipelined CPU: 32 registers of WIDTH bits, two combinational read ports for the ID stage, and one synchronous write port driven by the WB stage. The 5-bit write address is one-hot decoded by `decoder_32`, gated by `RegWrite`, and the one-hot result selects the single register that loads `WriteData` on the clock edge. Register ZERO_REG is hardwired to zero.

## Interface

- `WIDTH`, 64: data width of every register and data port.
- `ZERO_REG`, 31: index of the hardwired-zero register (XZR).

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on rising `clk`.
- `RegWrite`  in  1  write enable from WB stage; drives `decoder_32` enable.
- `WriteRegister`  in  5  destination register index.
- `WriteData`  in  WIDTH  data to write.
- `ReadRegister1`  in  5  read port 1 index.
- `ReadRegister2`  in  5  read port 2 index.
- `ReadData1`  out  WIDTH  contents of `ReadRegister1`.
- `ReadData2`  out  WIDTH  contents of `ReadRegister2`.

## Operation

- Storage: 32 x WIDTH flip-flop registers, `R[0]..R[31]`.
- Write decode: `decoder_32` with `in = WriteRegister` and `en = RegWrite` produces a 32-bit one-hot `wr_sel`. At most one bit is set, and no bit is set when `RegWrite = 0`.
- Write: on rising `clk` with `reset = 1`, every `R[i]` with `wr_sel[i] = 1` and `i != ZERO_REG` loads `WriteData`. All other registers hold.
- Zero register: `R[ZERO_REG]` is constant 0. A write to ZERO_REG is silently dropped, and reads of ZERO_REG return 0.
- Read: `ReadDataN` is a 32:1 mux over `R[]` indexed by `ReadRegisterN`. Both ports are fully independent and may address the same register.
- Reset: when `reset = 0` at a rising edge, all registers clear to 0. A concurrent `RegWrite` is ignored.
- Outputs after reset: `ReadData1 = ReadData2 = 0` for any index until the first write.

## Timing

- Write latency: data is presented in cycle N and is visible on a read port in cycle N+1. Same-cycle visibility depends on the bypass option (see Configuration).
- Read latency: 0 cycles (combinational from `ReadRegisterN` and current `R[]`).
- Reset mid-operation: reset dominates any pending write at that edge. The cycle after reset is deasserted, normal writes resume.
- Simultaneous write and read of the same index: governed by Configuration. The stored value always updates at the edge either way.
- Back-to-back writes to the same register: the last write wins, one per cycle, with no stall.
- `RegWrite = 0` with any `WriteRegister` value: no state change.
- Unknown or X `WriteRegister` with `RegWrite = 0`: no state change. Assertion: `$onehot0(wr_sel)` holds every cycle.

## Configuration

- Macro: `REGFILE_BYPASS_EN`.
- Defined: same-cycle write-to-read forwarding is enabled. If `RegWrite = 1`, `WriteRegister == ReadRegisterN`, and `WriteRegister != ZERO_REG`, then `ReadDataN = WriteData` combinationally. This removes the WB->ID hazard without requiring a write on the falling edge.
- Undefined: no forwarding. `ReadDataN` returns the pre-edge stored value during the write cycle, and the pipeline's hazard logic must stall or forward externally.
- In both builds, a read of ZERO_REG returns 0 and the stored state is identical.

## Test plan

- Reset clear: preload R5 = 0xDEAD, hold `reset = 0` for 1 edge, read R5 and R0 -> both 0. A write asserted during the reset edge (R7 = 0x1234) -> R7 reads 0.
- Basic write/read: write R0 = 0x1, R1 = 0xFFFF_FFFF_FFFF_FFFF, R30 = 0x0123_4567_89AB_CDEF on consecutive edges. Then read R1 on port 1 and R30 on port 2 -> exact values, and R0 = 0x1.
- Zero register: `RegWrite = 1`, `WriteRegister = 31`, `WriteData = 0xABCD`, one edge -> both ports reading 31 return 0, and no other register changes.
- Write disabled: `RegWrite = 0`, `WriteRegister = 4`, `WriteData = 0x55` -> R4 keeps its prior value (0 after reset).
- Same-cycle collision: R9 = 0x10, then in one cycle write R9 = 0x20 while both ports read 9. Before the edge, both ports -> 0x20 with `REGFILE_BYPASS_EN` and 0x10 without it. After the edge -> 0x20 in both builds.
- Exhaustive sweep: write `R[i] = i*0x0101` for i = 0..30, then read every index on both ports -> matching values, and R31 = 0.
